// File: rtl/stream_mux_rr_pkg.sv
// Shared definitions for the stream_mux_rr N:1 stream multiplexer.
package stream_mux_rr_pkg;

   // Index width for n entries, never narrower than one bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   typedef enum logic {
      MODE_FIXED = 1'b0,
      MODE_RR    = 1'b1
   } mode_e;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational rotate-priority search: first requester at or after ptr, wrapping.
module rr_arbiter #(
   parameter int unsigned NUM_IN = 5,
   parameter int unsigned SEL_W  = 3
) (
   input  logic [NUM_IN-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   output logic              gnt_valid,
   output logic [SEL_W-1:0]  gnt_idx
);

   always_comb begin
      logic [SEL_W:0] cand;
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 0; k < int'(NUM_IN); k++) begin
         cand = {1'b0, ptr} + (SEL_W+1)'(k);
         if (cand >= (SEL_W+1)'(NUM_IN)) begin
            cand = cand - (SEL_W+1)'(NUM_IN);
         end
         if (!gnt_valid && req[cand[SEL_W-1:0]]) begin
            gnt_valid = 1'b1;
            gnt_idx   = cand[SEL_W-1:0];
         end
      end
   end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream mux with registered output, fixed-select or round-robin grant.
module stream_mux_rr
   import stream_mux_rr_pkg::*;
#(
   parameter  int unsigned WIDTH  = 32,
   parameter  int unsigned NUM_IN = 5,
   localparam int unsigned SEL_W  = clog2_min1(NUM_IN)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_IN*WIDTH-1:0]  in_data,
   input  logic [NUM_IN-1:0]        in_valid,
   output logic [NUM_IN-1:0]        in_ready,
   input  logic                     rr_en,
   input  logic [SEL_W-1:0]         sel,
   output logic [WIDTH-1:0]         out_data,
   output logic [SEL_W-1:0]         out_src,
   output logic                     out_valid,
   input  logic                     out_ready
);

   logic [WIDTH-1:0] chan [NUM_IN];

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [SEL_W-1:0] out_src_q,   out_src_d;
   logic [SEL_W-1:0] ptr_q,       ptr_d;

   logic             arb_valid_c;
   logic [SEL_W-1:0] arb_idx_c;
   logic             fix_valid_c;
   logic             grant_valid_c;
   logic [SEL_W-1:0] grant_idx_c;
   logic             load_c;
   mode_e            mode_c;

   for (genvar i = 0; i < int'(NUM_IN); i++) begin : g_chan
      assign chan[i] = in_data[i*WIDTH +: WIDTH];
   end

   rr_arbiter #(
      .NUM_IN (NUM_IN),
      .SEL_W  (SEL_W)
   ) u_arb (
      .req       (in_valid),
      .ptr       (ptr_q),
      .gnt_valid (arb_valid_c),
      .gnt_idx   (arb_idx_c)
   );

   assign mode_c        = mode_e'(rr_en);
   assign fix_valid_c   = (32'(sel) < NUM_IN) && in_valid[sel];
   assign grant_valid_c = (mode_c == MODE_RR) ? arb_valid_c : fix_valid_c;
   assign grant_idx_c   = (mode_c == MODE_RR) ? arb_idx_c   : sel;
   // Output slot is free when empty or being drained this cycle.
   assign load_c        = !out_valid_q || out_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      ptr_d       = ptr_q;
      in_ready    = '0;
      if (load_c && !rst) begin
         if (grant_valid_c) begin
            in_ready[grant_idx_c] = 1'b1;
            out_valid_d           = 1'b1;
            out_data_d            = chan[grant_idx_c];
            out_src_d             = grant_idx_c;
            if (mode_c == MODE_RR) begin
               ptr_d = (grant_idx_c == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx_c + SEL_W'(1);
            end
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Randomized and directed bench for stream_mux_rr against a cycle-level reference model.
module tb_stream_mux_rr;

   localparam int unsigned WIDTH  = 32;
   localparam int unsigned NUM_IN = 5;
   localparam int unsigned SEL_W  = 3;

   logic                    clk;
   logic                    rst;
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [NUM_IN-1:0]       in_valid;
   logic [NUM_IN-1:0]       in_ready;
   logic                    rr_en;
   logic [SEL_W-1:0]        sel;
   logic [WIDTH-1:0]        out_data;
   logic [SEL_W-1:0]        out_src;
   logic                    out_valid;
   logic                    out_ready;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic             m_valid;
   logic [WIDTH-1:0] m_data;
   int               m_src;
   int               m_ptr;

   stream_mux_rr #(
      .WIDTH  (WIDTH),
      .NUM_IN (NUM_IN)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .rr_en     (rr_en),
      .sel       (sel),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] chan_word(input int i);
      return in_data[i*WIDTH +: WIDTH];
   endfunction

   // One clock: compare outputs and in_ready with the model, then advance both.
   task automatic step();
      int               g;
      logic             gv;
      logic             mload;
      logic [NUM_IN-1:0] er;
      logic             nv;
      logic [WIDTH-1:0] nd;
      int               ns;
      int               np;
      @(negedge clk);
      check("out_valid", 64'(out_valid), 64'(m_valid));
      check("out_data",  64'(out_data),  64'(m_data));
      check("out_src",   64'(out_src),   64'(m_src));
      mload = !m_valid || out_ready;
      gv = 1'b0;
      g  = 0;
      if (rr_en) begin
         for (int k = 0; k < int'(NUM_IN); k++) begin
            int idx;
            idx = (m_ptr + k) % int'(NUM_IN);
            if (!gv && in_valid[idx]) begin
               gv = 1'b1;
               g  = idx;
            end
         end
      end else if (int'(sel) < int'(NUM_IN) && in_valid[sel]) begin
         gv = 1'b1;
         g  = int'(sel);
      end
      er = '0;
      if (!rst && mload && gv) er[g] = 1'b1;
      check("in_ready", 64'(in_ready), 64'(er));
      nv = m_valid; nd = m_data; ns = m_src; np = m_ptr;
      if (rst) begin
         nv = 1'b0; nd = '0; ns = 0; np = 0;
      end else if (mload) begin
         if (gv) begin
            nv = 1'b1;
            nd = chan_word(g);
            ns = g;
            if (rr_en) np = (g + 1) % int'(NUM_IN);
         end else begin
            nv = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      m_valid = nv; m_data = nd; m_src = ns; m_ptr = np;
   endtask

   task automatic set_index_data();
      for (int i = 0; i < int'(NUM_IN); i++) in_data[i*WIDTH +: WIDTH] = WIDTH'(i);
   endtask

   task automatic set_random_data();
      for (int i = 0; i < int'(NUM_IN); i++) in_data[i*WIDTH +: WIDTH] = $urandom;
   endtask

   initial begin
      logic [WIDTH-1:0] held;
      rst = 1'b1; in_data = '0; in_valid = '0; rr_en = 1'b0; sel = '0; out_ready = 1'b0;
      @(posedge clk);
      #1;
      m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0;

      // Reset with all inputs valid
      in_valid = '1; rr_en = 1'b1; out_ready = 1'b1; set_index_data();
      step();
      step();
      rst = 1'b0;
      step();
      check("rst_first_src", 64'(out_src), 64'd0);
      check("rst_first_valid", 64'(out_valid), 64'd1);

      // Fixed select, then out-of-range select
      rr_en = 1'b0; sel = 3'd3;
      in_data[3*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
      step();
      check("fix_data", 64'(out_data), 64'hDEAD_BEEF);
      check("fix_src",  64'(out_src),  64'd3);
      sel = 3'd6;
      step();
      check("fix_oor_valid", 64'(out_valid), 64'd0);
      check("fix_oor_data",  64'(out_data),  64'hDEAD_BEEF);

      // Round-robin fairness
      rst = 1'b1; step(); rst = 1'b0;
      rr_en = 1'b1; in_valid = '1; out_ready = 1'b1; set_index_data();
      for (int i = 0; i < 10; i++) begin
         step();
         check("rr_src", 64'(out_src), 64'(i % 5));
         check("rr_data", 64'(out_data), 64'(i % 5));
      end

      // Sparse round-robin with wrap
      rst = 1'b1; step(); rst = 1'b0;
      in_valid = 5'b10010;
      for (int i = 0; i < 4; i++) begin
         step();
         check("sparse_src", 64'(out_src), (i % 2 == 0) ? 64'd1 : 64'd4);
      end

      // Back-pressure on a word from channel 2
      rst = 1'b1; step(); rst = 1'b0;
      rr_en = 1'b0; sel = 3'd2; in_valid = '1; out_ready = 1'b1; set_random_data();
      step();
      held = in_data[2*WIDTH +: WIDTH];
      check("bp_src0", 64'(out_src), 64'd2);
      out_ready = 1'b0; sel = 3'd3; set_random_data();
      for (int i = 0; i < 3; i++) begin
         step();
         check("bp_hold_src",   64'(out_src),   64'd2);
         check("bp_hold_data",  64'(out_data),  64'(held));
         check("bp_hold_valid", 64'(out_valid), 64'd1);
      end
      held = in_data[3*WIDTH +: WIDTH];
      out_ready = 1'b1;
      step();
      check("bp_next_src",  64'(out_src),  64'd3);
      check("bp_next_data", 64'(out_data), 64'(held));

      // Reset while a word is held
      rr_en = 1'b1; in_valid = '1; out_ready = 1'b1;
      step();
      step();
      out_ready = 1'b0;
      step();
      check("mid_held_valid", 64'(out_valid), 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      out_ready = 1'b1;
      step();
      check("mid_rst_ptr0", 64'(out_src), 64'd0);

      // Randomized traffic
      for (int i = 0; i < 500; i++) begin
         rst = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 7) == 0) rr_en = ~rr_en;
         sel = SEL_W'($urandom_range(0, 7));
         in_valid = NUM_IN'($urandom) & NUM_IN'($urandom | $urandom);
         out_ready = ($urandom_range(0, 9) < 7);
         set_random_data();
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N:1 stream multiplexer with a registered output stage and valid/ready handshakes on every input and on the output.
- Two modes, chosen at runtime:
  - fixed select: the sel index picks the input;
  - round-robin: arbitrates fairly among valid inputs.
- Used in the vector datapath wherever several producers share one consumer, e.g. writeback or result-bus merging.
- Replaces hard-wired combinational N:1 selects where back-pressure and fairness are needed.

Parameters:
- WIDTH, 32, data width of each channel.
- NUM_IN, 5, number of input channels; legal range 2..16.
- SEL_W, $clog2(NUM_IN), index width. Localparam, not overridable.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel ready; at most one bit is high per cycle.
- rr_en  input  1  1 = round-robin mode, 0 = fixed select mode.
- sel  input  SEL_W  channel index used in fixed mode; ignored when rr_en=1.
- out_data  output  WIDTH  registered data.
- out_src  output  SEL_W  index of the channel that supplied out_data.
- out_valid  output  1  out_data/out_src are valid.
- out_ready  input  1  consumer accepts the current output.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_src=0, round-robin pointer ptr=0.
  - A held, unaccepted word is dropped.
  - While rst=1, in_ready is all zeros.
- Load rule:
  - load = !out_valid || out_ready.
  - This gives full throughput of one word per cycle.
  - out_ready → in_ready is a combinational path, and this is intended.
- Grant, evaluated combinationally each cycle:
  - Fixed mode: grant is valid iff sel < NUM_IN and in_valid[sel]=1; g = sel. If sel >= NUM_IN, there is no grant and nothing is transferred.
  - Round-robin mode: g = the first index j with in_valid[j]=1, scanning ptr, ptr+1, …, NUM_IN-1, then 0, …, ptr-1. There is no grant if all in_valid are 0.
- Handshake:
  - in_ready[g] = load && grant_valid; all other in_ready bits are 0.
  - Input transfer happens when in_valid[g] && in_ready[g].
  - On a transfer, at the next edge: out_data=in_data[g], out_src=g, out_valid=1.
  - If load=1 and there is no grant: out_valid goes to 0 at the next edge, and out_data/out_src hold their old values.
  - If load=0: all outputs hold, and out_data is stable while out_valid && !out_ready.
- Latency: one cycle from input transfer to out_valid.
- Round-robin pointer:
  - Updates only on a transfer while rr_en=1: ptr <= (g == NUM_IN-1) ? 0 : g+1.
  - In fixed mode ptr holds.
- Mode change: a change of rr_en or sel affects only the next grant. A word already held in the output register is unaffected.
- Input protocol: inputs are not required to hold valid while not granted. The block makes no assumption either way.
- Fairness: in round-robin mode, with all inputs continuously valid and out_ready=1, each channel is granted exactly once every NUM_IN cycles.

Decomposition:
- Shared package:
  - a clog2-with-minimum-1 helper function;
  - a localparam type/constant for mode encoding (MODE_FIXED=0, MODE_RR=1).
- Sub-module rr_arbiter:
  - parameters NUM_IN, SEL_W;
  - inputs req[NUM_IN], ptr;
  - outputs gnt_valid, gnt_idx;
  - purely combinational rotate-priority search.
- The top level holds the output register, the ptr register, the load logic and the fixed/RR grant select.

Test Plan:
- Reset: assert rst for 2 cycles with all in_valid=1 → out_valid=0, out_data=0, out_src=0, in_ready=0 during reset; first grant afterwards comes from channel 0.
- Fixed mode: rr_en=0, sel=3, in_data[3]=32'hDEAD_BEEF, all valid, out_ready=1 → next cycle out_data=DEADBEEF, out_src=3; only in_ready[3] was high. Then sel=6 (≥NUM_IN) → no in_ready; out_valid drops to 0.
- Round-robin fairness: rr_en=1, all 5 channels valid with data = index, out_ready=1, 10 cycles → out_src sequence 0,1,2,3,4,0,1,2,3,4.
- Sparse round-robin with wrap: ptr=0, only channels 1 and 4 valid → out_src 1,4,1,4. After ptr moves past 4 it wraps to 0 and picks 1.
- Back-pressure: out_ready=0 for 3 cycles with a word from channel 2 held → out_data/out_src stable, out_valid=1, all in_ready=0. Raise out_ready → same-cycle load of the next granted word; no loss, no duplicate.
- Reset mid-operation: out_valid=1 with out_ready=0, pulse rst for 1 cycle → out_valid=0 and ptr=0. The held word is never accepted by the consumer.
